// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  // 43.2 MHz clock divided by 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 375;
  // 8N1 framing carries eight payload bits.
  localparam int DATA_BITS_DEFAULT    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking assignments make meta->q a real two-stage pipeline;
      // blocking ones would collapse it into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, mid-bit sampling, valid/ready output with overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            next_state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
  logic                 cnt_done;

  // Strobes decoded from the current state.
  logic                 start_fall;
  logic                 start_ok;
  logic                 bit_take;
  logic                 stop_ok;
  logic                 stop_bad;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign cnt_done = (cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: all bit decisions are taken at counter expiry.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // next_state unassigned and infers a latch.
    next_state = state;
    unique case (state)
      IDLE:      if (!rx_s)    next_state = START;
      START:     if (cnt_done) next_state = rx_s ? IDLE : DATA;
      DATA:      if (cnt_done && (bit_idx == LAST_IDX)) next_state = STOP;
      STOP:      if (cnt_done) next_state = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s)     next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Output strobes for the datapath and handshake registers.
  always_comb begin
    start_fall = (state == IDLE)  && !rx_s;
    start_ok   = (state == START) && cnt_done && !rx_s;
    bit_take   = (state == DATA)  && cnt_done;
    stop_ok    = (state == STOP)  && cnt_done && rx_s;
    stop_bad   = (state == STOP)  && cnt_done && !rx_s;
  end

  // Bit timer, bit index and payload shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      // NOTE: the shift register is cleared on reset only so that no X can
      // reach m_data; a new frame overwrites every bit before delivery anyway.
      shift_reg <= '0;
    end else if (start_fall) begin
      cnt <= HALF_LOAD;
    end else if (start_ok) begin
      cnt     <= FULL_LOAD;
      bit_idx <= '0;
    end else if (bit_take) begin
      shift_reg[bit_idx] <= rx_s;
      cnt                <= FULL_LOAD;
      if (bit_idx != LAST_IDX) bit_idx <= bit_idx + 1'b1;
    end else if ((state == START || state == DATA || state == STOP) && !cnt_done) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Output handshake: accept a new byte only if the holding register is free
  // or being emptied in this same cycle; otherwise drop it and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (stop_ok && (!m_valid || m_ready)) begin
        m_data  <= shift_reg;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // A new drop wins over a simultaneous clear.
      if (stop_ok && m_valid && !m_ready) overrun <= 1'b1;
      else if (clr_overrun)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard and a decoupled monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLKS = 375;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fe_cycles = 0;
  int rises = 0;
  int rise_cyc = 0;
  int frame_start = 0;

  logic [7:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [7:0] prev_data = '0;

  uart_rx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and tracks pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cycles++;
      if (m_valid && !prev_valid) begin
        rises++;
        rise_cyc = cyc;
      end
      if (prev_valid && !prev_xfer && m_valid)
        check("m_data_stable", int'(m_data), int'(prev_data));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte got=0x%0h expected=none", m_data);
        end else begin
          check("sb_byte", int'(m_data), int'(exp_q.pop_front()));
        end
      end
      prev_valid = m_valid;
      prev_xfer  = m_valid && m_ready;
      prev_data  = m_data;
    end else begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  // Sends start, 8 data bits LSB first, then the given stop level (left driven).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    frame_start = cyc;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int fe0, r0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // 0x55 with m_ready=1: one pulse, timed from the start-bit edge.
    // Line falls after edge E0; 2 sync flops + 1 IDLE->START edge = 3,
    // 187 cycles to mid start bit, 9 bit times (8 data + stop) = 3375.
    m_ready = 1'b1;
    r0 = rises;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain("drain_55");
    check("pulses_55", rises - r0, 1);
    check("latency_55", rise_cyc - frame_start, 3 + 187 + 9 * CLKS);
    check("valid_dropped_55", int'(m_valid), 0);

    // Glitch: 100 low cycles must not start a frame.
    fe0 = fe_cycles;
    r0 = rises;
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check("glitch_no_valid", rises - r0, 0);
    check("glitch_no_fe", fe_cycles - fe0, 0);

    // 0xA3 with a low stop bit, line held low, then 0x3C.
    fe0 = fe_cycles;
    r0 = rises;
    send_frame(8'hA3, 1'b0);
    repeat (2000) @(posedge clk);
    #1;
    check("fe_pulse_A3", fe_cycles - fe0, 1);
    check("fe_no_valid_A3", rises - r0, 0);
    hold_bit(1'b1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain("drain_3C");
    check("fe_total_after_3C", fe_cycles - fe0, 1);

    // Overrun: 0x11 then 0x22 with m_ready=0.
    m_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("ovr_valid", int'(m_valid), 1);
    check("ovr_data_held", int'(m_data), 8'h11);
    check("ovr_flag", int'(overrun), 1);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    check("ovr_data_after_clr", int'(m_data), 8'h11);

    // Clear coinciding with a new drop (delivery edge E0+3565) keeps overrun set.
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (3 + 187 + 9 * CLKS - 1) @(posedge clk);
        #1;
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
      end
    join
    check("ovr_clr_collision", int'(overrun), 1);
    check("ovr_data_after_33", int'(m_data), 8'h11);
    m_ready = 1'b1;
    wait_drain("drain_11");

    // Reset during data bit 4 of 0xF0, then 0x0F.
    r0 = rises;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b0);
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_valid", int'(m_valid), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_data", int'(m_data), 0);
    rst_n = 1'b1;
    repeat (2 * CLKS) @(posedge clk);
    #1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_drain("drain_0F");
    check("midrst_one_byte", rises - r0, 1);

    // Back-to-back 0x00 and 0xFF.
    fe0 = fe_cycles;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("drain_b2b");
    check("b2b_no_fe", fe_cycles - fe0, 0);

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
